trigger_arm_sequencer: RTL
==========================

TRIGGER_ARM_SEQUENCER -- requirements
Module: trigger_arm_sequencer

Interface
REQ-001 SHALL have parameter SHOT_WIDTH, default 16, width of shot count and num_shots.
REQ-002 SHALL have parameter TIMER_WIDTH, default 32, width of holdoff and timeout values.
REQ-003 SHALL have port clk  input  1  single clock; all logic is rising-edge.
REQ-004 SHALL have port aresetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a run.
REQ-006 SHALL have port abort  input  1  one-cycle request to end a run.
REQ-007 SHALL have port num_shots  input  SHOT_WIDTH  triggers per run; 0 means continuous.
REQ-008 SHALL have port holdoff  input  TIMER_WIDTH  idle cycles between trigger clear and re-arm.
REQ-009 SHALL have port timeout  input  TIMER_WIDTH  max WAIT_TRIG cycles; 0 disables.
REQ-010 SHALL have port trig_fired  input  1  trigger output of the delayed-trigger block.
REQ-011 SHALL have port trig_enable  output  1  enable to the delayed-trigger block.
REQ-012 SHALL have port arm  output  1  one-cycle arm pulse to the delayed-trigger block.
REQ-013 SHALL have port trigger_reset  output  1  one-cycle clear pulse to the delayed-trigger block.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  sticky; run completed num_shots triggers.
REQ-016 SHALL have port timed_out  output  1  sticky; run ended by timeout.
REQ-017 SHALL have port shot_count  output  SHOT_WIDTH  triggers counted in current/last run.
REQ-018 SHALL have port state  output  3  current FSM state encoding.

Function
REQ-019 SHALL implement states IDLE=0, ARM=1, WAIT_TRIG=2, CLEAR=3, HOLDOFF=4; all outputs registered.
REQ-020 IDLE: on start, SHALL latch num_shots/holdoff/timeout, zero shot_count, clear done and timed_out, go ARM; config changes mid-run SHALL be ignored.
REQ-021 ARM: SHALL assert arm for exactly that one cycle, zero the timeout timer, go WAIT_TRIG; arm is high in the cycle after start is sampled.
REQ-022 WAIT_TRIG: SHALL detect a rising edge of trig_fired (registered previous value, updated every cycle); a level already high on entry SHALL NOT count.
REQ-023 On edge: shot_count increments (wraps modulo 2^SHOT_WIDTH); go CLEAR; run is final if latched num_shots != 0 and new shot_count == num_shots.
REQ-024 Timeout: if latched timeout != 0, timer increments per WAIT_TRIG cycle; when timer == timeout-1 with no edge, SHALL set timed_out and go CLEAR as final.
REQ-025 Edge and timeout in the same cycle: edge SHALL win; timed_out stays 0.
REQ-026 CLEAR: SHALL assert trigger_reset for exactly one cycle; if final or aborting go IDLE (done=1 only when final via shot count), else load holdoff and go HOLDOFF.
REQ-027 HOLDOFF: SHALL decrement counter, go ARM when counter is 0; holdoff=0 gives one HOLDOFF cycle, holdoff=N gives N+1.
REQ-028 trig_enable SHALL equal busy, registered.
REQ-029 abort in any non-IDLE, non-CLEAR state SHALL go CLEAR as aborting next cycle; done stays 0; shot_count holds.
REQ-030 abort in CLEAR SHALL mark the CLEAR as aborting (go IDLE, no done); abort in IDLE SHALL be ignored.
REQ-031 start while busy SHALL be ignored; start and abort together in IDLE: abort wins, start ignored.
REQ-032 Trigger edges outside WAIT_TRIG SHALL be ignored and not counted.
REQ-033 Continuous mode (num_shots=0) SHALL loop until abort or timeout; done never set.

Reset
REQ-034 aresetn low SHALL asynchronously force state IDLE, arm=0, trigger_reset=0, trig_enable=0, busy=0, done=0, timed_out=0, shot_count=0, all timers and edge register 0.
REQ-035 Reset mid-run SHALL abandon the run with no trigger_reset pulse; operation resumes on first clock after release.

Verification
REQ-036 num_shots=3, holdoff=10, timeout=0, 3 trig_fired pulses each after arm -> 3 arm pulses, 3 trigger_reset pulses, shot_count=3, done=1, busy=0.
REQ-037 num_shots=2, timeout=50, no trig_fired -> timed_out=1 at 50 cycles in WAIT_TRIG, one trigger_reset, done=0, shot_count=0.
REQ-038 num_shots=0, holdoff=0, abort after 5 triggers -> shot_count=5, one trigger_reset after abort, IDLE, done=0.
REQ-039 trig_fired held high through arm, and pulses during HOLDOFF -> not counted; shot_count unchanged.
REQ-040 Edge on cycle timer==timeout-1 -> counted, timed_out=0; start while busy and start+abort in IDLE -> ignored.
REQ-041 aresetn low during WAIT_TRIG -> all outputs 0 immediately; new start after release runs normally.

Source files
------------

// File: rtl/trigger_arm_sequencer.sv
// Run sequencer for a delayed-trigger block: arms it, counts trigger edges, clears it,
// waits a holdoff, and repeats until the shot count, a timeout, or an abort ends the run.
module trigger_arm_sequencer #(
    parameter int SHOT_WIDTH  = 16,
    parameter int TIMER_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [SHOT_WIDTH-1:0]  num_shots,
    input  logic [TIMER_WIDTH-1:0] holdoff,
    input  logic [TIMER_WIDTH-1:0] timeout,
    input  logic                   trig_fired,
    output logic                   trig_enable,
    output logic                   arm,
    output logic                   trigger_reset,
    output logic                   busy,
    output logic                   done,
    output logic                   timed_out,
    output logic [SHOT_WIDTH-1:0]  shot_count,
    output logic [2:0]             state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
        WAIT_TRIG = 3'd2,
        CLEAR     = 3'd3,
        HOLDOFF   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [SHOT_WIDTH-1:0]  num_shots_q, num_shots_d;
    logic [TIMER_WIDTH-1:0] holdoff_q, holdoff_d;
    logic [TIMER_WIDTH-1:0] timeout_q, timeout_d;
    logic [SHOT_WIDTH-1:0]  shot_count_q, shot_count_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic [TIMER_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
    logic                   trig_prev_q;
    logic                   final_q, final_d;
    logic                   aborting_q, aborting_d;
    logic                   done_q, done_d;
    logic                   timed_out_q, timed_out_d;
    logic                   arm_q, trig_rst_q, busy_q;
    logic                   trig_edge;
    logic [SHOT_WIDTH-1:0]  shot_inc;

    assign trig_edge = trig_fired & ~trig_prev_q;
    assign shot_inc  = shot_count_q + SHOT_WIDTH'(1);

    always_comb begin
        state_d      = state_q;
        num_shots_d  = num_shots_q;
        holdoff_d    = holdoff_q;
        timeout_d    = timeout_q;
        shot_count_d = shot_count_q;
        timer_d      = timer_q;
        hold_cnt_d   = hold_cnt_q;
        final_d      = final_q;
        aborting_d   = aborting_q;
        done_d       = done_q;
        timed_out_d  = timed_out_q;
        case (state_q)
            IDLE: begin
                // abort beats a simultaneous start
                if (start && !abort) begin
                    num_shots_d  = num_shots;
                    holdoff_d    = holdoff;
                    timeout_d    = timeout;
                    shot_count_d = '0;
                    done_d       = 1'b0;
                    timed_out_d  = 1'b0;
                    final_d      = 1'b0;
                    aborting_d   = 1'b0;
                    state_d      = ARM;
                end
            end
            ARM: begin
                if (abort) begin
                    aborting_d = 1'b1;
                    state_d    = CLEAR;
                end else begin
                    timer_d = '0;
                    state_d = WAIT_TRIG;
                end
            end
            WAIT_TRIG: begin
                if (abort) begin
                    aborting_d = 1'b1;
                    state_d    = CLEAR;
                end else if (trig_edge) begin
                    shot_count_d = shot_inc;
                    final_d      = (num_shots_q != '0) && (shot_inc == num_shots_q);
                    state_d      = CLEAR;
                end else if (timeout_q != '0) begin
                    if (timer_q == timeout_q - TIMER_WIDTH'(1)) begin
                        timed_out_d = 1'b1;
                        final_d     = 1'b1;
                        state_d     = CLEAR;
                    end else begin
                        timer_d = timer_q + TIMER_WIDTH'(1);
                    end
                end
            end
            CLEAR: begin
                if (abort || aborting_q) begin
                    state_d = IDLE;
                end else if (final_q) begin
                    // a timeout-terminated run is final but not done
                    done_d  = ~timed_out_q;
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = holdoff_q;
                    state_d    = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (abort) begin
                    aborting_d = 1'b1;
                    state_d    = CLEAR;
                end else if (hold_cnt_q == '0) begin
                    state_d = ARM;
                end else begin
                    hold_cnt_d = hold_cnt_q - TIMER_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            num_shots_q  <= '0;
            holdoff_q    <= '0;
            timeout_q    <= '0;
            shot_count_q <= '0;
            timer_q      <= '0;
            hold_cnt_q   <= '0;
            trig_prev_q  <= 1'b0;
            final_q      <= 1'b0;
            aborting_q   <= 1'b0;
            done_q       <= 1'b0;
            timed_out_q  <= 1'b0;
            arm_q        <= 1'b0;
            trig_rst_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_shots_q  <= num_shots_d;
            holdoff_q    <= holdoff_d;
            timeout_q    <= timeout_d;
            shot_count_q <= shot_count_d;
            timer_q      <= timer_d;
            hold_cnt_q   <= hold_cnt_d;
            trig_prev_q  <= trig_fired;
            final_q      <= final_d;
            aborting_q   <= aborting_d;
            done_q       <= done_d;
            timed_out_q  <= timed_out_d;
            // pulse outputs are decoded from the next state so they line up with it
            arm_q        <= (state_d == ARM);
            trig_rst_q   <= (state_d == CLEAR);
            busy_q       <= (state_d != IDLE);
        end
    end

    assign state         = state_q;
    assign arm           = arm_q;
    assign trigger_reset = trig_rst_q;
    assign busy          = busy_q;
    assign trig_enable   = busy_q;
    assign done          = done_q;
    assign timed_out     = timed_out_q;
    assign shot_count    = shot_count_q;

endmodule
